// File: rtl/ahb_decoder_mux_if.sv
// AHB-Lite bus bundle between the master, the decoder/mux and the two slaves.
// The decoder sits on the slave modport; the master/bench drives the master modport.
interface ahb_decoder_mux_if;
   logic [31:0] i_HADDR;
   logic [1:0]  i_HTRANS;
   logic [31:0] i_alu_HRDATA;
   logic [1:0]  i_alu_HRESP;
   logic        i_alu_HREADY;
   logic [31:0] i_mul_HRDATA;
   logic [1:0]  i_mul_HRESP;
   logic        i_mul_HREADY;
   logic        o_HSEL_alu;
   logic        o_HSEL_mul;
   logic [31:0] o_HRDATA;
   logic [1:0]  o_HRESP;
   logic        o_HREADY;
   logic [7:0]  o_err_cnt;

   modport slave (
      input  i_HADDR, i_HTRANS,
      input  i_alu_HRDATA, i_alu_HRESP, i_alu_HREADY,
      input  i_mul_HRDATA, i_mul_HRESP, i_mul_HREADY,
      output o_HSEL_alu, o_HSEL_mul, o_HRDATA, o_HRESP, o_HREADY, o_err_cnt
   );

   modport master (
      output i_HADDR, i_HTRANS,
      output i_alu_HRDATA, i_alu_HRESP, i_alu_HREADY,
      output i_mul_HRDATA, i_mul_HRESP, i_mul_HREADY,
      input  o_HSEL_alu, o_HSEL_mul, o_HRDATA, o_HRESP, o_HREADY, o_err_cnt
   );
endinterface

// File: rtl/ahb_decoder_mux.sv
// AHB-Lite address decoder, data-phase response mux and built-in default slave
// that answers active transfers to unmapped addresses with a two-cycle ERROR.
module ahb_decoder_mux #(
   parameter logic [31:0] ALU_BASE    = 32'h0000_0000,
   parameter logic [31:0] MUL_BASE    = 32'h0000_1000,
   parameter int          REGION_BITS = 12
) (
   input logic              HCLK,
   input logic              HRESETn,
   ahb_decoder_mux_if.slave bus
);
   localparam logic [1:0] RESP_OKAY  = 2'b00;
   localparam logic [1:0] RESP_ERROR = 2'b01;

   typedef enum logic [1:0] {SEL_DEF, SEL_ALU, SEL_MUL} sel_t;
   typedef enum logic [1:0] {DS_IDLE, DS_ERR1, DS_ERR2} ds_t;

   logic        hit_alu, hit_mul, unmapped, active;
   logic        ds_start, ds_en;
   sel_t        dsel_nxt, r_dsel;
   ds_t         ds_state, ds_nxt;
   logic        ds_ready;
   logic [1:0]  ds_resp;
   logic [7:0]  r_err_cnt;
   logic        hready;
   logic [1:0]  hresp;
   logic [31:0] hrdata;

   assign hit_alu  = (bus.i_HADDR[31:REGION_BITS] == ALU_BASE[31:REGION_BITS]);
   assign hit_mul  = (bus.i_HADDR[31:REGION_BITS] == MUL_BASE[31:REGION_BITS]);
   assign unmapped = ~hit_alu & ~hit_mul;
   assign active   = (bus.i_HTRANS == 2'b10) | (bus.i_HTRANS == 2'b11);

   assign bus.o_HSEL_alu = hit_alu;
   assign bus.o_HSEL_mul = hit_mul;

   always_comb begin
      dsel_nxt = SEL_DEF;
      if (hit_alu)      dsel_nxt = SEL_ALU;
      else if (hit_mul) dsel_nxt = SEL_MUL;
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn)    r_dsel <= SEL_DEF;
      else if (hready) r_dsel <= dsel_nxt;
   end

   // Default slave only moves while it owns the data phase or is being handed it.
   assign ds_start = hready & unmapped & active;
   assign ds_en    = (r_dsel == SEL_DEF) | (hready & unmapped);

   always_comb begin
      ds_nxt   = ds_state;
      ds_ready = 1'b1;
      ds_resp  = RESP_OKAY;
      case (ds_state)
         DS_IDLE: if (ds_start) ds_nxt = DS_ERR1;
         DS_ERR1: begin
            ds_ready = 1'b0;
            ds_resp  = RESP_ERROR;
            ds_nxt   = DS_ERR2;
         end
         DS_ERR2: begin
            ds_resp = RESP_ERROR;
            ds_nxt  = ds_start ? DS_ERR1 : DS_IDLE;
         end
         default: ds_nxt = DS_IDLE;
      endcase
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn)   ds_state <= DS_IDLE;
      else if (ds_en) ds_state <= ds_nxt;
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn)
         r_err_cnt <= 8'd0;
      else if (ds_en && ds_state == DS_ERR2 && r_err_cnt != 8'hFF)
         r_err_cnt <= r_err_cnt + 8'd1;
   end

   always_comb begin
      hrdata = 32'd0;
      hresp  = ds_resp;
      hready = ds_ready;
      case (r_dsel)
         SEL_ALU: begin
            hrdata = bus.i_alu_HRDATA;
            hresp  = bus.i_alu_HRESP;
            hready = bus.i_alu_HREADY;
         end
         SEL_MUL: begin
            hrdata = bus.i_mul_HRDATA;
            hresp  = bus.i_mul_HRESP;
            hready = bus.i_mul_HREADY;
         end
         default: ;
      endcase
   end

   assign bus.o_HRDATA  = hrdata;
   assign bus.o_HRESP   = hresp;
   assign bus.o_HREADY  = hready;
   assign bus.o_err_cnt = r_err_cnt;
endmodule
